// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states
//   PC_STEP       : byte increment between sequential instruction words
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_WAIT,
    FS_DISCARD
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop head entry (ignored when empty)
//   flush    : empty the FIFO; overrides push and pop
//   wdata    : entry to write
//   rdata    : head entry, reads 0 when empty
//   empty, full, count : occupancy status
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-aligned PC stream, single-outstanding memory
// reads, prefetch FIFO towards the decoder, and redirect with flush.
//   clk, rst            : clock, synchronous active-high reset
//   imem_req/imem_addr  : one-cycle read request and its word address
//   imem_rvalid/rdata   : read response
//   redirect_valid/pc   : load new PC and flush buffered/in-flight words
//   instr_valid/instr/instr_pc : FIFO head presented to the decoder
//   next_instr          : decoder consumes the head this cycle
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           BUS_WIDTH  = 32,
  parameter int unsigned           PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_rvalid,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 instr_valid,
  output logic [BUS_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]  instr_pc,
  input  logic                 next_instr
);

  localparam int unsigned EntryW = PC_WIDTH + BUS_WIDTH;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                push, pop;
  logic [EntryW-1:0]   head;
  logic                fifo_empty, fifo_full;
  logic [CntW-1:0]     fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    imem_req = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        if (fifo_count < CntW'(FIFO_DEPTH)) begin
          imem_req = 1'b1;
          pc_d     = pc_q + PC_WIDTH'(PC_STEP);
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = FS_IDLE;
        end
      end
      FS_DISCARD: begin
        if (imem_rvalid) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
    if (redirect_valid) begin
      imem_req = 1'b0;
      push     = 1'b0;
      pc_d     = redirect_pc & ~PC_WIDTH'(3);
      // A fetch still in flight must have its response swallowed.
      if ((state_q == FS_WAIT || state_q == FS_DISCARD) && !imem_rvalid) begin
        state_d = FS_DISCARD;
      end else begin
        state_d = FS_IDLE;
      end
    end
    if (rst) imem_req = 1'b0;
  end

  assign imem_addr   = rst ? RESET_PC : pc_q;
  assign instr_valid = !fifo_empty && !rst;
  assign pop         = instr_valid && next_instr;
  assign instr_pc    = rst ? '0 : head[EntryW-1:BUS_WIDTH];
  assign instr       = rst ? '0 : head[BUS_WIDTH-1:0];

  // pc_q already advanced at issue, so the outstanding word sits one step back.
  fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q - PC_WIDTH'(PC_STEP), imem_rdata}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Issue requires a free slot, so a response always fits.
  always_ff @(posedge clk) begin
    if (!rst && push) assert (!fifo_full);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model and a
// scoreboard of words the decoder is expected to receive.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, redirect_valid, instr_valid, next_instr;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .BUS_WIDTH  (32),
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .next_instr     (next_instr)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  logic [63:0] exp_q[$];
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] pop_pc_q[$];
  int          pop_cyc_q[$];
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_delay;
  int          pend_epoch;
  int          mem_lat = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] at32(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  function automatic int at_int(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    pop_pc_q.delete();
    pop_cyc_q.delete();
  endtask

  // One clock cycle: sample the current cycle, then drive memory for the next.
  task automatic tick();
    logic        req_s, redir_s, rst_s;
    logic [31:0] addr_s;
    logic [63:0] e;
    #1;
    req_s   = imem_req;
    addr_s  = imem_addr;
    redir_s = redirect_valid;
    rst_s   = rst;
    if (req_s) begin
      req_addr_q.push_back(addr_s);
      req_cyc_q.push_back(cyc);
    end
    if (instr_valid && next_instr && !redir_s && !rst_s) begin
      chk("sb_entry_available", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", {32'b0, instr_pc}, {32'b0, e[63:32]});
        chk("instr", {32'b0, instr}, {32'b0, e[31:0]});
      end
      pop_pc_q.push_back(instr_pc);
      pop_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (redir_s || rst_s) begin
      epoch++;
      exp_q.delete();
    end
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (req_s) begin
      pend       = 1'b1;
      pend_addr  = addr_s;
      pend_delay = mem_lat;
      pend_epoch = epoch;
    end
    if (pend) begin
      pend_delay--;
      if (pend_delay <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ KEY;
        if (pend_epoch == epoch) exp_q.push_back({pend_addr, pend_addr ^ KEY});
        pend = 1'b0;
      end
    end
  endtask

  initial begin
    int  rel;
    int  redir_cyc;
    bit  found;

    rst            = 1'b1;
    next_instr     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_instr_pc", 64'(instr_pc), 64'h0);

    // Streaming with 1-cycle memory
    rst        = 1'b0;
    next_instr = 1'b1;
    mem_lat    = 1;
    cyc        = 1;
    clear_logs();
    repeat (6) tick();
    chk("stream_req0_cyc", 64'(at_int(req_cyc_q, 0)), 64'd1);
    chk("stream_req1_cyc", 64'(at_int(req_cyc_q, 1)), 64'd3);
    chk("stream_req2_cyc", 64'(at_int(req_cyc_q, 2)), 64'd5);
    chk("stream_req0_addr", 64'(at32(req_addr_q, 0)), 64'h0);
    chk("stream_req1_addr", 64'(at32(req_addr_q, 1)), 64'h4);
    chk("stream_req2_addr", 64'(at32(req_addr_q, 2)), 64'h8);
    chk("stream_pop0_pc", 64'(at32(pop_pc_q, 0)), 64'h0);
    chk("stream_pop1_pc", 64'(at32(pop_pc_q, 1)), 64'h4);
    chk("stream_pop0_cyc", 64'(at_int(pop_cyc_q, 0)), 64'd3);

    // Back-pressure: FIFO fills, requests stop
    next_instr = 1'b0;
    repeat (6) tick();
    clear_logs();
    repeat (4) tick();
    #1;
    chk("full_no_req_logged", 64'(req_addr_q.size()), 64'd0);
    chk("full_req_now", 64'(imem_req), 64'd0);
    chk("full_buffered", 64'(exp_q.size()), 64'd2);
    chk("full_valid", 64'(instr_valid), 64'd1);
    clear_logs();
    next_instr = 1'b1;
    rel        = cyc;
    repeat (3) tick();
    chk("release_req_cyc", 64'(at_int(req_cyc_q, 0)), 64'(rel + 1));
    chk("release_req_addr", 64'(at32(req_addr_q, 0)), 64'h10);

    // Redirect while a fetch is outstanding
    mem_lat = 3;
    clear_logs();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_addr_q.size() != 0) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_found_req", 64'(found), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    redir_cyc      = cyc;
    clear_logs();
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_wait_valid", 64'(instr_valid), 64'd0);
    repeat (10) tick();
    chk("redir_wait_req_addr", 64'(at32(req_addr_q, 0)), 64'h100);
    chk("redir_wait_req_cyc", 64'(at_int(req_cyc_q, 0)), 64'(redir_cyc + 3));
    chk("redir_wait_pop_pc", 64'(at32(pop_pc_q, 0)), 64'h100);

    // Redirect coincident with a response and a consume
    mem_lat = 1;
    found   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_rvalid) begin
        found = 1'b1;
        break;
      end
    end
    chk("coinc_found_rvalid", 64'(found), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    next_instr     = 1'b1;
    clear_logs();
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_valid", 64'(instr_valid), 64'd0);
    chk("coinc_req", 64'(imem_req), 64'd1);
    chk("coinc_addr", 64'(imem_addr), 64'h200);
    repeat (6) tick();
    chk("coinc_pop_pc", 64'(at32(pop_pc_q, 0)), 64'h200);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    clear_logs();
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    chk("wrap_req0_addr", 64'(at32(req_addr_q, 0)), 64'hFFFF_FFFC);
    chk("wrap_req1_addr", 64'(at32(req_addr_q, 1)), 64'h0);
    chk("wrap_pop0_pc", 64'(at32(pop_pc_q, 0)), 64'hFFFF_FFFC);
    chk("wrap_pop1_pc", 64'(at32(pop_pc_q, 1)), 64'h0);

    // Reset with a fetch outstanding; stale response lands after release
    mem_lat = 3;
    clear_logs();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_addr_q.size() != 0) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid_found_req", 64'(found), 64'd1);
    rst = 1'b1;
    tick();
    #1;
    chk("rstmid_req", 64'(imem_req), 64'd0);
    chk("rstmid_addr", 64'(imem_addr), 64'h0);
    chk("rstmid_valid", 64'(instr_valid), 64'd0);
    chk("rstmid_instr", 64'(instr), 64'h0);
    chk("rstmid_instr_pc", 64'(instr_pc), 64'h0);
    tick();
    rst = 1'b0;
    rel = cyc;
    clear_logs();
    repeat (10) tick();
    chk("rstmid_req_cyc", 64'(at_int(req_cyc_q, 0)), 64'(rel));
    chk("rstmid_req_addr", 64'(at32(req_addr_q, 0)), 64'h0);
    chk("rstmid_pop_pc", 64'(at32(pop_pc_q, 0)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. Generates a word-aligned PC stream and issues single-outstanding read requests to instruction memory. Buffers returned words in a small prefetch FIFO and presents them to the decoder with a valid/next handshake. Supports a PC redirect (branch/jump) that flushes buffered and in-flight instructions.

## Interface
- BUS_WIDTH, 32, instruction word width
- PC_WIDTH, 32, program counter / memory address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2)

Reset is synchronous, active-high, on the single clock `clk`.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  read request, valid for one cycle per request
- imem_addr  out  PC_WIDTH  request address (always [1:0]=0)
- imem_rvalid  in  1  read data valid
- imem_rdata  in  BUS_WIDTH  read data
- redirect_valid  in  1  load new PC, flush pipeline
- redirect_pc  in  PC_WIDTH  redirect target ([1:0] ignored)
- instr_valid  out  1  FIFO head holds a valid instruction (to decoder)
- instr  out  BUS_WIDTH  instruction at FIFO head
- instr_pc  out  PC_WIDTH  PC of instruction at FIFO head
- next_instr  in  1  decoder consumes head this cycle

## Operation
- State machine (FS_IDLE, FS_WAIT, FS_DISCARD); pc register; FIFO of {pc, instr}.
- FS_IDLE: if count < FIFO_DEPTH and !redirect_valid, assert imem_req with imem_addr = pc; pc += 4 (wraps modulo 2^PC_WIDTH); → FS_WAIT. Otherwise imem_req = 0.
- FS_WAIT: on imem_rvalid, push {request pc, imem_rdata}; → FS_IDLE. The FIFO cannot overflow, since issue requires free space.
- FS_DISCARD: on imem_rvalid, drop data; → FS_IDLE.
- imem_rvalid in FS_IDLE is ignored.
- Pop when instr_valid && next_instr. next_instr with FIFO empty is ignored.
- Simultaneous push and pop: count unchanged, order preserved.
- Redirect (highest priority, any state):
  - pc ← {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - FIFO cleared; a same-cycle push or pop is discarded.
  - No request issued this cycle.
  - State → FS_DISCARD if in FS_WAIT without same-cycle imem_rvalid, or already in FS_DISCARD without imem_rvalid.
  - Otherwise state → FS_IDLE.
- instr/instr_pc read as 0 when FIFO empty.

## Timing
- Reset values:
  - imem_req=0 while rst high.
  - imem_addr=RESET_PC, pc=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - FIFO empty, state FS_IDLE.
- First request in the first cycle after rst deasserts; imem_addr=RESET_PC.
- imem_req/imem_addr are combinational from state, count, pc and redirect_valid. Memory has no back-pressure; a request is accepted when asserted.
- imem_rvalid arrives ≥1 cycle after the request.
- Latency:
  - rvalid in cycle N → instr_valid=1 in N+1.
  - Next request no earlier than N+1.
  - Peak throughput with 1-cycle memory: one word per 2 cycles.
- Redirect in cycle N:
  - instr_valid=0 in N+1.
  - Request to the redirect target in N+1 if no fetch is outstanding; otherwise in the cycle after the discarded response.
- Reset mid-fetch: the outstanding response arriving after reset is ignored (state FS_IDLE).

## Structure
- fetch_pkg: fetch_state_t enum {FS_IDLE, FS_WAIT, FS_DISCARD}; PC_STEP = 4.
- Sub-module fetch_fifo: synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, data in, head data out, empty, full, count.
  - flush overrides push and pop.
- fetch_unit holds the FSM and pc, and instantiates fetch_fifo with WIDTH = PC_WIDTH+BUS_WIDTH.

## Test plan
- Reset, 1-cycle memory returning addr^32'hA5A5_0000, next_instr=1 → requests at 0x0, 0x4, 0x8 in cycles 1, 3, 5; instr_pc 0x0, 0x4, 0x8 in order with matching data.
- next_instr=0 held → exactly FIFO_DEPTH words buffered, then imem_req stays 0. Release → next request issued the cycle after the first pop.
- Redirect to 0x103 while FS_WAIT → next cycle instr_valid=0. Late rvalid is dropped. Next request at 0x100, and its word is presented with instr_pc=0x100.
- Redirect coincident with imem_rvalid and next_instr → FIFO empty next cycle, request at redirect target in the next cycle, no stale instruction presented.
- pc at 0xFFFF_FFFC → following request at 0x0000_0000.
- rst asserted with request outstanding, then rvalid arrives after release → response ignored, first request at RESET_PC, all outputs at reset values during rst.
